// File: rtl/sseg_scroller.sv
// Scrolling message source for a 4-digit 7-segment display: buffered character writes,
// prescaled right-to-left scroll. Optional inter-repetition gap via SSEG_SCROLL_GAP_EN.
module sseg_scroller #(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 25000000
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   wr_valid,
  input  logic [4:0]             wr_char,
  output logic                   wr_ready,
  input  logic                   clear,
  input  logic                   run,
  output logic [$clog2(DEPTH):0] msg_len,
  output logic [7:0]             dig_3,
  output logic [7:0]             dig_2,
  output logic [7:0]             dig_1,
  output logic [7:0]             dig_0
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = $clog2(DEPTH + 8);   // holds len_eff and pos+3 without overflow
  localparam int PW = $clog2(TICK_DIV);

  logic [4:0]    msg_buf [DEPTH];
  logic [LW-1:0] len;
  logic [EW-1:0] pos;
  logic [EW-1:0] len_eff;
  logic [PW-1:0] presc;
  logic          alive;
  logic          tick;
  logic [EW-1:0] idx      [4];
  logic [7:0]    win_seg  [4];

  function automatic logic [7:0] seg_of(input logic [4:0] c);
    case (c)
      5'h00: seg_of = 8'hC0;  5'h01: seg_of = 8'hF9;
      5'h02: seg_of = 8'hA4;  5'h03: seg_of = 8'hB0;
      5'h04: seg_of = 8'h99;  5'h05: seg_of = 8'h92;
      5'h06: seg_of = 8'h82;  5'h07: seg_of = 8'hF8;
      5'h08: seg_of = 8'h80;  5'h09: seg_of = 8'h90;
      5'h0A: seg_of = 8'h88;  5'h0B: seg_of = 8'h83;
      5'h0C: seg_of = 8'hC6;  5'h0D: seg_of = 8'hA1;
      5'h0E: seg_of = 8'h86;  5'h0F: seg_of = 8'h8E;
      5'h11: seg_of = 8'hBF;
      default: seg_of = 8'hFF;
    endcase
  endfunction

`ifdef SSEG_SCROLL_GAP_EN
  assign len_eff = (len != '0) ? EW'(len) + EW'(4) : '0;
`else
  assign len_eff = EW'(len);
`endif

  // alive keeps wr_ready low until the first edge that samples resetn high
  assign wr_ready = alive && (len < LW'(DEPTH)) && !clear;
  assign msg_len  = len;
  assign tick     = run && (presc == PW'(TICK_DIV - 1));

  // Static messages never wrap: unused right-hand digits are blank, not repeats.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      idx[k] = pos + EW'(k);
      if ((len_eff > EW'(4)) && (idx[k] >= len_eff))
        idx[k] = idx[k] - len_eff;
      if (idx[k] < EW'(len))
        win_seg[k] = seg_of(msg_buf[idx[k][AW-1:0]]);
      else
        win_seg[k] = 8'hFF;
    end
  end

  // NOTE: the message buffer has no reset; len gates every read, so stale entries are never shown.
  always_ff @(posedge clk) begin
    if (wr_valid && wr_ready)
      msg_buf[len[AW-1:0]] <= wr_char;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      alive <= 1'b0;
      len   <= '0;
      pos   <= '0;
      presc <= '0;
      dig_3 <= 8'hFF;
      dig_2 <= 8'hFF;
      dig_1 <= 8'hFF;
      dig_0 <= 8'hFF;
    end else begin
      alive <= 1'b1;
      dig_3 <= win_seg[0];
      dig_2 <= win_seg[1];
      dig_1 <= win_seg[2];
      dig_0 <= win_seg[3];
      if (clear) begin
        len   <= '0;
        pos   <= '0;
        presc <= '0;
      end else begin
        if (wr_valid && wr_ready)
          len <= len + LW'(1);
        if (run)
          presc <= tick ? '0 : presc + PW'(1);
        if (len_eff <= EW'(4))
          pos <= '0;
        else if (tick)
          pos <= (pos >= len_eff - EW'(1)) ? '0 : pos + EW'(1);
      end
    end
  end

endmodule
